// File: rtl/loopback_pkt_buffer.sv
// Avalon-ST loopback packet buffer: show-ahead FIFO with a framing checker that
// emits one msg_enter pulse per completed message and flags framing violations.
module loopback_pkt_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 16,
    localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    input  logic                   in_startofpacket,
    input  logic                   in_endofpacket,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    output logic                   out_startofpacket,
    output logic                   out_endofpacket,
    input  logic                   out_ready,
    output logic                   msg_enter,
    output logic                   pkt_error,
    output logic [LEVEL_WIDTH-1:0] fill_level
);
    localparam int PTR_W   = LEVEL_WIDTH - 1;
    localparam int ENTRY_W = DATA_WIDTH + 2;
    localparam logic [LEVEL_WIDTH-1:0] DEPTH_L = LEVEL_WIDTH'(FIFO_DEPTH);

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0] head;
    logic               push, pop, wr_en;
    logic               msg_nxt, err_nxt;

    assign in_ready  = ~rst & (fill_level < DEPTH_L);
    assign out_valid = (fill_level != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign head              = mem[rd_ptr];
    assign out_data          = out_valid ? head[DATA_WIDTH-1:0] : '0;
    assign out_endofpacket   = out_valid & head[DATA_WIDTH];
    assign out_startofpacket = out_valid & head[DATA_WIDTH+1];

    // Framing decisions only happen on an accepted beat; a stray
    // non-sop beat outside a message is handshaken but never stored.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        msg_nxt   = 1'b0;
        err_nxt   = 1'b0;
        if (push) begin
            case (state)
                IDLE: begin
                    if (in_startofpacket) begin
                        wr_en = 1'b1;
                        if (in_endofpacket) msg_nxt = 1'b1;
                        else                state_nxt = IN_PKT;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                IN_PKT: begin
                    wr_en = 1'b1;
                    if (in_startofpacket) err_nxt = 1'b1;
                    if (in_endofpacket) begin
                        msg_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            msg_enter <= 1'b0;
            pkt_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            msg_enter <= msg_nxt;
            pkt_error <= err_nxt;
        end
    end

    // Storage needs no reset: the empty-gating on out_* hides stale entries.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {in_startofpacket, in_endofpacket, in_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   fill_level <= fill_level + 1'b1;
                2'b01:   fill_level <= fill_level - 1'b1;
                default: fill_level <= fill_level;
            endcase
        end
    end
endmodule

// File: tb/tb_loopback_pkt_buffer.sv
// Directed bench for loopback_pkt_buffer: framing pulses, show-ahead order,
// full/backpressure handling, wrap-around and mid-message reset.
module tb_loopback_pkt_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid, in_startofpacket, in_endofpacket, in_ready;
    logic [31:0] out_data;
    logic        out_valid, out_startofpacket, out_endofpacket, out_ready;
    logic        msg_enter, pkt_error;
    logic [4:0]  fill_level;

    int checks   = 0;
    int failures = 0;
    int msg_cnt  = 0;
    int err_cnt  = 0;
    int msg_base, err_base;
    logic [33:0] exp_q[$];
    logic [33:0] got_q[$];

    loopback_pkt_buffer #(.DATA_WIDTH(32), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid),
        .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
        .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid),
        .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
        .out_ready(out_ready),
        .msg_enter(msg_enter), .pkt_error(pkt_error), .fill_level(fill_level)
    );

    always #5 clk = ~clk;

    // Record pulses and every beat the sink accepts.
    always @(negedge clk) begin
        if (msg_enter) msg_cnt++;
        if (pkt_error) err_cnt++;
        if (out_valid && out_ready)
            got_q.push_back({out_startofpacket, out_endofpacket, out_data});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [31:0] d, input logic s, input logic e, input logic stored);
        int n;
        in_data = d; in_startofpacket = s; in_endofpacket = e; in_valid = 1'b1;
        if (stored) exp_q.push_back({s, e, d});
        n = 0;
        while (!in_ready && n < 64) begin
            step();
            n++;
        end
        chk("push_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (fill_level != 5'd0 && n < 100) begin
            step();
            n++;
        end
        chk("drain_done", 64'(fill_level), 64'd0);
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_beat"}, 64'(got_q[i]), 64'(exp_q[i]));
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0;
        in_startofpacket = 1'b0; in_endofpacket = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_fill", 64'(fill_level), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_msg", 64'(msg_enter), 64'd0);
        chk("rst_err", 64'(pkt_error), 64'd0);
        step(); step();
        rst = 1'b0;
        step();

        // Single-beat message, sink ready
        out_ready = 1'b1;
        in_data = 32'hA5A5_0001; in_startofpacket = 1'b1; in_endofpacket = 1'b1; in_valid = 1'b1;
        exp_q.push_back({1'b1, 1'b1, 32'hA5A5_0001});
        chk("t1_ready", 64'(in_ready), 64'd1);
        chk("t1_no_same_cycle", 64'(out_valid), 64'd0);
        step();
        in_valid = 1'b0;
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_data", 64'(out_data), 64'hA5A5_0001);
        chk("t1_sop", 64'(out_startofpacket), 64'd1);
        chk("t1_eop", 64'(out_endofpacket), 64'd1);
        chk("t1_msg", 64'(msg_enter), 64'd1);
        chk("t1_fill1", 64'(fill_level), 64'd1);
        step();
        chk("t1_msg_off", 64'(msg_enter), 64'd0);
        chk("t1_fill0", 64'(fill_level), 64'd0);
        chk("t1_empty", 64'(out_valid), 64'd0);
        chk("t1_msg_cnt", 64'(msg_cnt), 64'd1);
        cmp_stream("t1");

        // 4-beat message behind a stalled sink
        out_ready = 1'b0;
        msg_base = msg_cnt;
        push_beat(32'h10, 1'b1, 1'b0, 1'b1);
        chk("t2_msg_b0", 64'(msg_enter), 64'd0);
        push_beat(32'h11, 1'b0, 1'b0, 1'b1);
        push_beat(32'h12, 1'b0, 1'b0, 1'b1);
        chk("t2_msg_b2", 64'(msg_enter), 64'd0);
        push_beat(32'h13, 1'b0, 1'b1, 1'b1);
        chk("t2_msg_eop", 64'(msg_enter), 64'd1);
        chk("t2_fill4", 64'(fill_level), 64'd4);
        chk("t2_head", 64'(out_data), 64'h10);
        chk("t2_head_sop", 64'(out_startofpacket), 64'd1);
        step();
        chk("t2_msg_off", 64'(msg_enter), 64'd0);
        chk("t2_hold", 64'(out_data), 64'h10);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_order", 64'(out_data), 64'(32'h10 + i));
            chk("t2_eop", 64'(out_endofpacket), 64'(i == 3));
            step();
        end
        chk("t2_fill0", 64'(fill_level), 64'd0);
        chk("t2_msg_cnt", 64'(msg_cnt - msg_base), 64'd1);
        cmp_stream("t2");

        // Fill to full, hold off the 17th beat, then stream with wrap-around
        out_ready = 1'b0;
        msg_base = msg_cnt; err_base = err_cnt;
        push_beat(32'h100, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i < 16; i++) push_beat(32'h100 + i, 1'b0, 1'b0, 1'b1);
        chk("t3_fill16", 64'(fill_level), 64'd16);
        chk("t3_full", 64'(in_ready), 64'd0);
        chk("t3_head", 64'(out_data), 64'h100);
        in_data = 32'h1FF; in_startofpacket = 1'b0; in_endofpacket = 1'b0; in_valid = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 32'h1FF});
        step();
        chk("t3_holdoff_fill", 64'(fill_level), 64'd16);
        chk("t3_holdoff_rdy", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t3_pop_rdy", 64'(in_ready), 64'd1);
        chk("t3_pop_fill", 64'(fill_level), 64'd15);
        chk("t3_pop_head", 64'(out_data), 64'h101);
        step();
        in_valid = 1'b0;
        chk("t3_refill", 64'(fill_level), 64'd16);
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) push_beat(32'h200 + i, 1'b0, i == 39, 1'b1);
        drain();
        chk("t3_msg_cnt", 64'(msg_cnt - msg_base), 64'd1);
        chk("t3_err_cnt", 64'(err_cnt - err_base), 64'd0);
        cmp_stream("t3");

        // Stray non-sop beat while idle is discarded
        msg_base = msg_cnt;
        push_beat(32'hDEAD, 1'b0, 1'b0, 1'b0);
        chk("t4_err", 64'(pkt_error), 64'd1);
        chk("t4_msg", 64'(msg_enter), 64'd0);
        chk("t4_fill", 64'(fill_level), 64'd0);
        chk("t4_out_valid", 64'(out_valid), 64'd0);
        step();
        chk("t4_err_off", 64'(pkt_error), 64'd0);
        chk("t4_msg_cnt", 64'(msg_cnt - msg_base), 64'd0);
        cmp_stream("t4");

        // sop inside an open message
        out_ready = 1'b0;
        msg_base = msg_cnt; err_base = err_cnt;
        push_beat(32'h300, 1'b1, 1'b0, 1'b1);
        push_beat(32'h301, 1'b0, 1'b0, 1'b1);
        chk("t5_err_mid", 64'(pkt_error), 64'd0);
        push_beat(32'h302, 1'b1, 1'b1, 1'b1);
        chk("t5_err", 64'(pkt_error), 64'd1);
        chk("t5_msg", 64'(msg_enter), 64'd1);
        chk("t5_fill", 64'(fill_level), 64'd3);
        out_ready = 1'b1;
        drain();
        chk("t5_msg_cnt", 64'(msg_cnt - msg_base), 64'd1);
        chk("t5_err_cnt", 64'(err_cnt - err_base), 64'd1);
        cmp_stream("t5");

        // Reset with 5 beats stored mid-message
        out_ready = 1'b0;
        push_beat(32'h400, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i < 5; i++) push_beat(32'h400 + i, 1'b0, 1'b0, 1'b1);
        chk("t6_fill5", 64'(fill_level), 64'd5);
        msg_base = msg_cnt; err_base = err_cnt;
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_fill", 64'(fill_level), 64'd0);
        chk("t6_rst_ready", 64'(in_ready), 64'd0);
        exp_q.delete();
        got_q.delete();
        step();
        rst = 1'b0;
        step();
        chk("t6_no_pulse_msg", 64'(msg_cnt - msg_base), 64'd0);
        chk("t6_no_pulse_err", 64'(err_cnt - err_base), 64'd0);
        out_ready = 1'b1;
        push_beat(32'h500, 1'b1, 1'b1, 1'b1);
        chk("t6_msg", 64'(msg_enter), 64'd1);
        chk("t6_err", 64'(pkt_error), 64'd0);
        chk("t6_data", 64'(out_data), 64'h500);
        drain();
        chk("t6_msg_cnt", 64'(msg_cnt - msg_base), 64'd1);
        cmp_stream("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
